led_bank_arbiter: RTL and testbench

//  Shares the 6-LED bank between NUM_REQ requesters (counter display, status, error codes, ...).

---
 rtl/led_bank_arbiter.sv | 98 +++++++++
 tb/tb_led_bank_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/led_bank_arbiter.sv
// rtl/led_bank_arbiter.sv - round-robin owner of the LED bank with a guaranteed minimum hold time
// Define LED_ARB_HEARTBEAT_EN to blink LED0 every HOLD_TICKS cycles while idle.
module led_bank_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int LED_WIDTH  = 6,
  parameter int HOLD_TICKS = 1048576
) (
  input  logic                         in_clk,
  input  logic                         in_rst,
  input  logic [NUM_REQ-1:0]           in_req,
  input  logic [NUM_REQ*LED_WIDTH-1:0] in_pattern,
  output logic [NUM_REQ-1:0]           out_grant,
  output logic [LED_WIDTH-1:0]         out_led,
  output logic                         out_busy
);
  localparam int IDXW = $clog2(NUM_REQ);
  localparam int TW   = $clog2(HOLD_TICKS + 1);
  localparam logic [TW-1:0] LAST_TICK = TW'(HOLD_TICKS - 1);

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_OPEN} state_t;

  state_t               state;
  logic [IDXW-1:0]      owner;
  logic [IDXW-1:0]      rr_ptr;
  logic [IDXW-1:0]      win;
  logic [TW-1:0]        timer;
  logic [NUM_REQ-1:0]   cand;
  logic                 any_cand;
  logic                 decide;
  logic [LED_WIDTH-1:0] pat [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign pat[g] = in_pattern[g*LED_WIDTH +: LED_WIDTH];
  end

  // The current owner is masked out, so a handoff always lands on a different requester.
  assign cand     = in_req & ~out_grant;
  assign any_cand = |cand;
  assign decide   = (state == S_OPEN) || ((state == S_HOLD) && (timer == LAST_TICK));

  always_comb begin
    int   idx;
    logic found;
    idx   = 0;
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && cand[idx[IDXW-1:0]]) begin
        found = 1'b1;
        win   = idx[IDXW-1:0];
      end
    end
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state     <= S_IDLE;
      owner     <= '0;
      rr_ptr    <= '0;
      timer     <= '0;
      out_grant <= '0;
      out_busy  <= 1'b0;
      out_led   <= '1;
    end else if (((state == S_IDLE) || decide) && any_cand) begin
      state     <= S_HOLD;
      owner     <= win;
      rr_ptr    <= (win == IDXW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
      timer     <= '0;
      out_grant <= NUM_REQ'(1) << win;
      out_busy  <= 1'b1;
      out_led   <= ~pat[win];
    end else if (state == S_IDLE) begin
`ifdef LED_ARB_HEARTBEAT_EN
      if (timer == LAST_TICK) begin
        timer      <= '0;
        out_led[0] <= ~out_led[0];
      end else begin
        timer <= timer + 1'b1;
      end
`else
      out_led <= '1;
`endif
    end else if (decide && !in_req[owner]) begin
      state     <= S_IDLE;
      timer     <= '0;
      out_grant <= '0;
      out_busy  <= 1'b0;
      out_led   <= '1;
    end else begin
      if (decide) state <= S_OPEN;
      else        timer <= timer + 1'b1;
      // A dropped owner request freezes the last displayed pattern.
      if (in_req[owner]) out_led <= ~pat[owner];
    end
  end
endmodule

// File: tb/tb_led_bank_arbiter.sv
// tb/tb_led_bank_arbiter.sv - directed and randomized checks of led_bank_arbiter against an ownership model
module tb_led_bank_arbiter;
  localparam int NR   = 4;
  localparam int LW   = 6;
  localparam int HOLD = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NR-1:0]    req = '0;
  logic [NR*LW-1:0] pattern = '0;
  logic [NR-1:0]    grant;
  logic [LW-1:0]    led;
  logic             busy;

  int ncmp  = 0;
  int nfail = 0;

  led_bank_arbiter #(.NUM_REQ(NR), .LED_WIDTH(LW), .HOLD_TICKS(HOLD)) dut (
    .in_clk(clk), .in_rst(rst), .in_req(req), .in_pattern(pattern),
    .out_grant(grant), .out_led(led), .out_busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: owner index (-1 = nobody), cycles owned so far, last granted index.
  int            m_owner = -1;
  int            m_owned = 0;
  int            m_last  = NR - 1;
  int            m_idle  = 0;
  logic          m_hb    = 1'b0;
  logic [LW-1:0] m_pat   = '0;
  logic [NR-1:0] exp_grant = '0;
  logic [LW-1:0] exp_led   = '1;
  logic          exp_busy  = 1'b0;

  function automatic int pick(input logic [NR-1:0] r, input int last);
    int idx;
    for (int k = 1; k <= NR; k++) begin
      idx = (last + k) % NR;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    int            w;
    logic [NR-1:0] others;
    w = -1;
    others = req;
    if (rst) begin
      m_owner = -1; m_last = NR - 1; m_idle = 0; m_hb = 1'b0;
    end else if (m_owner < 0) begin
      w = pick(req, m_last);
      if (w >= 0) begin
        m_owner = w; m_owned = 1; m_last = w; m_pat = pattern[w*LW +: LW];
      end else begin
        m_idle++;
        if (m_idle == HOLD) begin m_idle = 0; m_hb = ~m_hb; end
      end
    end else if (m_owned < HOLD) begin
      m_owned++;
      if (req[m_owner]) m_pat = pattern[m_owner*LW +: LW];
    end else begin
      others[m_owner] = 1'b0;
      w = pick(others, m_last);
      if (w >= 0) begin
        m_owner = w; m_owned = 1; m_last = w; m_pat = pattern[w*LW +: LW];
      end else if (req[m_owner]) begin
        m_pat = pattern[m_owner*LW +: LW];
      end else begin
        m_owner = -1; m_idle = 0; m_hb = 1'b0;
      end
    end
    exp_grant = (m_owner >= 0) ? (NR'(1) << m_owner) : '0;
    exp_busy  = (m_owner >= 0);
`ifdef LED_ARB_HEARTBEAT_EN
    exp_led   = (m_owner >= 0) ? ~m_pat : {5'b11111, ~m_hb};
`else
    exp_led   = (m_owner >= 0) ? ~m_pat : 6'b111111;
`endif
  end

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = '0;
    repeat (2) @(negedge clk);
    ncmp++; if (grant !== '0 || busy !== 1'b0 || led !== 6'b111111) begin
      nfail++; $display("FAIL reset_values: grant=%b busy=%b led=%h, want 0000/0/3f", grant, busy, led);
    end
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      ncmp++; if (grant !== 4'b0000 || busy !== 1'b0) begin
        nfail++; $display("FAIL idle_grant c%0d: grant=%b busy=%b, want 0000/0", c, grant, busy);
      end
      ncmp++; if (led !== exp_led) begin
        nfail++; $display("FAIL idle_led c%0d: led=%h, want %h", c, led, exp_led);
      end
`ifndef LED_ARB_HEARTBEAT_EN
      ncmp++; if (led !== 6'b111111) begin
        nfail++; $display("FAIL idle_led_off c%0d: led=%h, want 3f", c, led);
      end
`else
      ncmp++; if (led[5:1] !== 5'b11111) begin
        nfail++; $display("FAIL heartbeat_upper c%0d: led=%h, want 5'b11111 on [5:1]", c, led);
      end
`endif
    end
  endtask

  task automatic test_single();
    logic [NR-1:0] want;
    do_reset();
    pattern = 24'($urandom);
    pattern[5:0] = 6'h2A;
    req = 4'b0001;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      want = (c <= HOLD) ? 4'b0001 : 4'b0000;
      ncmp++; if (grant !== want || busy !== (c <= HOLD)) begin
        nfail++; $display("FAIL single_grant c%0d: grant=%b busy=%b, want %b", c, grant, busy, want);
      end
      ncmp++; if (c <= HOLD ? (led !== 6'h15) : (led !== exp_led)) begin
        nfail++; $display("FAIL single_led c%0d: led=%h, want %h", c, led, (c <= HOLD) ? 6'h15 : exp_led);
      end
      pattern[23:6] = 18'($urandom);
      if (c == 2) begin
        req = 4'b0000;
        pattern[5:0] = ~6'h2A;
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [NR-1:0] want;
    do_reset();
    pattern = 24'($urandom);
    req = 4'b1010;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      want = (((c - 1) / HOLD) % 2 == 0) ? 4'b0010 : 4'b1000;
      ncmp++; if (grant !== want || busy !== 1'b1) begin
        nfail++; $display("FAIL simul_grant c%0d: grant=%b busy=%b, want %b/1", c, grant, busy, want);
      end
      ncmp++; if (led !== exp_led) begin
        nfail++; $display("FAIL simul_led c%0d: led=%h, want %h", c, led, exp_led);
      end
      pattern = 24'($urandom);
    end
  endtask

  task automatic test_hold_no_preempt();
    logic [NR-1:0] want;
    do_reset();
    pattern = 24'($urandom);
    req = 4'b0001;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      want = (c <= HOLD) ? 4'b0001 : 4'b0100;
      ncmp++; if (grant !== want) begin
        nfail++; $display("FAIL preempt_grant c%0d: grant=%b, want %b", c, grant, want);
      end
      ncmp++; if (led !== exp_led) begin
        nfail++; $display("FAIL preempt_led c%0d: led=%h, want %h", c, led, exp_led);
      end
      if (c == 2) req = 4'b0101;
    end
  endtask

  task automatic test_reset_mid_hold();
    do_reset();
    pattern = 24'($urandom);
    req = 4'b0010;
    repeat (2) @(negedge clk);
    ncmp++; if (grant !== 4'b0010) begin
      nfail++; $display("FAIL midrst_pre: grant=%b, want 0010", grant);
    end
    rst = 1'b1;
    @(negedge clk);
    ncmp++; if (grant !== 4'b0000 || busy !== 1'b0 || led !== 6'b111111) begin
      nfail++; $display("FAIL midrst_drop: grant=%b busy=%b led=%h, want 0000/0/3f", grant, busy, led);
    end
    rst = 1'b0;
    req = 4'b1111;
    @(negedge clk);
    ncmp++; if (grant !== 4'b0001 || busy !== 1'b1 || led !== ~pattern[5:0]) begin
      nfail++; $display("FAIL midrst_regrant: grant=%b busy=%b led=%h, want 0001/1/%h", grant, busy, led, ~pattern[5:0]);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      ncmp++; if (grant !== exp_grant || busy !== exp_busy || led !== exp_led) begin
        nfail++; $display("FAIL random c%0d: grant=%b busy=%b led=%h, want %b/%b/%h", c, grant, busy, led, exp_grant, exp_busy, exp_led);
      end
      ncmp++; if (busy !== (|grant) || !$onehot0(grant)) begin
        nfail++; $display("FAIL random_onehot c%0d: grant=%b busy=%b, want one-hot and busy=|grant", c, grant, busy);
      end
      rst = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < NR; i++)
        if ($urandom_range(0, 7) == 0) req[i] = ~req[i];
      pattern = 24'($urandom);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_hold_no_preempt();
    test_reset_mid_hold();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
